ifetch_requester: RTL and testbench

//  Instruction-fetch initiator: owns the PC, issues read requests to the instruction memory
//  and buffers returned instructions in a small prefetch FIFO for decode.

---
 rtl/ifetch_requester.sv | 154 +++++++++++++++
 tb/tb_ifetch_requester.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_requester.sv
// Instruction-fetch initiator: owns the PC, issues one imem read at a time, buffers results in a prefetch FIFO.
// Optional macro FETCH_TIMEOUT_EN: abandon a silent request after TIMEOUT cycles, retry it, and raise sticky fetch_err_o.
module ifetch_requester #(
    parameter int unsigned     WORD     = 64,
    parameter int unsigned     INSTR    = 32,
    parameter int unsigned     FIFO_AW  = 2,
    parameter logic [WORD-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WORD-1:0]  imem_addr_o,
    output logic             imem_read_o,
    input  logic [INSTR-1:0] imem_rdata_i,
    input  logic             imem_valid_i,
    input  logic             pc_src_i,
    input  logic [WORD-1:0]  branch_target_i,
    output logic [INSTR-1:0] instr_out_o,
    output logic [WORD-1:0]  instr_pc_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic             fetch_err_o
);
    localparam int unsigned      DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    if (TIMEOUT < 1 || FIFO_AW < 1) begin : g_bad_param
        $error("ifetch_requester: TIMEOUT and FIFO_AW must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    typedef struct packed {
        logic [WORD-1:0]  pc;
        logic [INSTR-1:0] instr;
    } entry_t;

    state_t             state_q, state_d;
    logic [WORD-1:0]    pc_q, pc_d;
    logic [WORD-1:0]    addr_q, addr_d;
    entry_t             fifo_q [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               push, pop, tmo_hit;

    // A redirect squashes both the landing response and any decode pop in that cycle.
    assign push = (state_q == WAIT) && imem_valid_i && !pc_src_i;
    assign pop  = instr_valid_o && instr_ready_i && !pc_src_i;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q;
    logic          waiting;

    assign waiting = (state_q == WAIT) || (state_q == DROP);
    assign tmo_hit = waiting && !imem_valid_i && (tmo_q >= TW'(TIMEOUT - 1));

    // Counter keeps running across a WAIT->DROP redirect: it is the same outstanding response.
    always_comb begin
        tmo_d = '0;
        if (waiting && (state_d == WAIT || state_d == DROP))
            tmo_d = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (tmo_hit && !pc_src_i) err_q <= 1'b1;
        end
    end

    assign fetch_err_o = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!pc_src_i && cnt_q < FULL_CNT) state_d = REQ;
            REQ:  state_d = pc_src_i ? DROP : WAIT;
            WAIT: begin
                if (imem_valid_i)  state_d = IDLE;
                else if (pc_src_i) state_d = DROP;
                else if (tmo_hit)  state_d = IDLE;
            end
            DROP: if (imem_valid_i || (tmo_hit && !pc_src_i)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        addr_d   = addr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (pc_src_i) begin
            pc_d     = branch_target_i & ~WORD'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + WORD'(4);
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        // Address is latched on entry to REQ and held until the next request.
        if (state_q == IDLE && state_d == REQ) addr_d = pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{pc: pc_q, instr: imem_rdata_i};
    end

    assign imem_read_o   = (state_q == REQ);
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (cnt_q != '0);
    assign instr_pc_o    = fifo_q[rd_ptr_q].pc;
    assign instr_out_o   = fifo_q[rd_ptr_q].instr;

endmodule

// File: tb/tb_ifetch_requester.sv
// Randomized bench for ifetch_requester: transaction-level reference model of fetch order,
// redirect squashing and FIFO contents, plus directed reset/latency/redirect/timeout scenarios.
module tb_ifetch_requester;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        pc_src;
    logic [63:0] branch_target;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    ifetch_requester dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr_o(imem_addr), .imem_read_o(imem_read),
        .imem_rdata_i(imem_rdata), .imem_valid_i(imem_valid),
        .pc_src_i(pc_src), .branch_target_i(branch_target),
        .instr_out_o(instr_out), .instr_pc_o(instr_pc),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .fetch_err_o(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] pops[$];
    int          n_chk = 0, n_err = 0;
    logic [63:0] m_pc = 64'h0;
    bit          out_busy = 0, out_drop = 0;
    logic [63:0] out_addr = 64'h0;
    bit          mem_pend = 0;
    int          mem_wait = 0;
    logic [63:0] mem_addr = 64'h0;
    int          lat_lo = 1, lat_hi = 1, rdy_pct = 100, br_pct = 0, spur_pct = 0;
    bit          mute = 0, stale = 0, br_now = 0, gap_chk = 0;
    logic [63:0] br_tgt = 64'h0;
    int          cyc = 0, last_rd = -1, n_rd = 0;
    bit          saw_rd = 0;
    logic [63:0] rd_addr = 64'h0;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return 32'hAAAA0000 + a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: updates expected FIFO contents and fetch PC from the cycle's observed events.
    task automatic observe();
        logic [63:0] pc0;
        bit          room0, pop;
        pc0    = m_pc;
        room0  = exp_q.size() < 4;
        saw_rd = 0;
        chk("instr_valid", instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("head_pc", instr_pc, exp_q[0].pc);
            chk("head_instr", instr_out, exp_q[0].ins);
        end
`ifndef FETCH_TIMEOUT_EN
        chk("fetch_err_off", fetch_err, 0);
`endif
        pop = instr_valid && instr_ready && !pc_src;
        if (pop) pops.push_back(instr_pc);
        if (pc_src) begin
            exp_q.delete();
            m_pc = branch_target & ~64'h3;
            if (out_busy) begin
                out_drop = 1;
                if (imem_valid) out_busy = 0;
            end
        end else begin
            if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
            if (imem_valid && out_busy) begin
                if (!out_drop) begin
                    exp_q.push_back('{out_addr, memf(out_addr)});
                    m_pc = m_pc + 64'd4;
                end
                out_busy = 0;
            end
        end
        if (imem_read) begin
            chk("one_outstanding", out_busy, 0);
            chk("req_addr", imem_addr, pc0);
            chk("req_room", room0, 1);
            if (gap_chk && last_rd >= 0) chk("req_gap", cyc - last_rd, 3);
            last_rd  = cyc;
            out_busy = 1;
            out_drop = pc_src;
            out_addr = pc0;
            mem_pend = 1;
            mem_addr = imem_addr;
            mem_wait = int'($urandom_range(lat_hi - 1, lat_lo - 1));
            saw_rd   = 1;
            rd_addr  = imem_addr;
            n_rd++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (stale) begin
            imem_valid = 1'b1;
            stale      = 0;
        end else if (mem_pend && !mute) begin
            if (mem_wait == 0) begin
                imem_valid = 1'b1;
                imem_rdata = memf(mem_addr);
                mem_pend   = 0;
            end else mem_wait--;
        end else if (!mem_pend && !out_busy && int'($urandom_range(99)) < spur_pct) begin
            imem_valid = 1'b1;
        end
        instr_ready = int'($urandom_range(99)) < rdy_pct;
        pc_src = 1'b0;
        if (br_now) begin
            pc_src        = 1'b1;
            branch_target = br_tgt;
            br_now        = 0;
        end else if (int'($urandom_range(99)) < br_pct) begin
            pc_src        = 1'b1;
            branch_target = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15))
                                                     : {$urandom, $urandom};
        end
        @(negedge clk);
        observe();
    endtask

    task automatic model_clear();
        exp_q.delete();
        pops.delete();
        m_pc     = 64'h0;
        out_busy = 0;
        out_drop = 0;
        mem_pend = 0;
        last_rd  = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        pc_src     = 1'b0;
        br_now     = 0;
        #1;
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_read", imem_read, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_err", fetch_err, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_read(input int lim);
        int k;
        k = 0;
        tick();
        while (!saw_rd && k < lim) begin
            tick();
            k++;
        end
        chk("wait_read", saw_rd, 1);
    endtask

    task automatic wait_valid(input int lim);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!instr_valid && k < lim);
        chk("wait_valid", instr_valid, 1);
    endtask

    task automatic wait_pops(input int n, input int lim);
        int k;
        k = 0;
        while (pops.size() < n && k < lim) begin
            tick();
            k++;
        end
        chk("wait_pops", pops.size() >= n, 1);
    endtask

    initial begin
        int          k;
        int          n0;
        logic [63:0] a0;
        imem_valid = 0; imem_rdata = 0; pc_src = 0; branch_target = 0; instr_ready = 1;

        // Sequential fetch with 1-cycle memory: latency, order, throughput.
        lat_lo = 1; lat_hi = 1; rdy_pct = 100; gap_chk = 1;
        do_reset();
        k = 0;
        do begin
            tick();
            k++;
        end while (!instr_valid && k < 10);
        chk("first_latency", k, 3);
        wait_pops(4, 40);
        for (int i = 0; i < 4 && i < pops.size(); i++) chk("s1_seq", pops[i], 64'(4 * i));
        gap_chk = 0;

        // Back-pressure: four requests fill the FIFO, then drain in order and resume at 0x10.
        rdy_pct = 0;
        do_reset();
        n_rd = 0;
        repeat (40) tick();
        chk("s2_nreq", n_rd, 4);
        chk("s2_full_valid", instr_valid, 1);
        rdy_pct = 100;
        wait_read(40);
        chk("s2_resume", rd_addr, 64'h10);
        wait_pops(4, 40);
        for (int i = 0; i < 4 && i < pops.size(); i++) chk("s2_seq", pops[i], 64'(4 * i));

        // Redirect during WAIT with data still in the FIFO.
        lat_lo = 3; lat_hi = 3; rdy_pct = 0;
        do_reset();
        wait_read(20);
        wait_read(20);
        wait_read(20);
        br_now = 1; br_tgt = 64'h103;
        tick();
        tick();
        chk("s3_flushed", instr_valid, 0);
        rdy_pct = 100;
        wait_read(20);
        chk("s3_addr", rd_addr, 64'h100);
        wait_valid(20);
        chk("s3_pc", instr_pc, 64'h100);

        // Redirect in the same cycle as the response.
        lat_lo = 1; lat_hi = 1;
        do_reset();
        wait_read(20);
        br_now = 1; br_tgt = 64'h200;
        tick();
        wait_read(20);
        chk("s4_addr", rd_addr, 64'h200);
        wait_valid(20);
        chk("s4_pc", instr_pc, 64'h200);

        // Random traffic: latencies, back-pressure, redirects (incl. near-wrap), spurious strobes.
        lat_lo = 1; lat_hi = 3; rdy_pct = 70; br_pct = 5; spur_pct = 5;
        repeat (1500) tick();

        // Asynchronous reset while a request is outstanding; stale strobe afterwards.
        br_pct = 0; spur_pct = 0; lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        repeat (10) tick();
        rdy_pct = 0;
        repeat (4) tick();
        mute = 1;
        wait_read(20);
        tick();
        chk("s5_pre_valid", instr_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s5_addr", imem_addr, 64'h0);
        chk("s5_valid", instr_valid, 0);
        chk("s5_read", imem_read, 0);
        model_clear();
        mute = 0;
        rdy_pct = 100;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1;
        wait_read(10);
        chk("s5_restart", rd_addr, 64'h0);
        wait_valid(20);
        chk("s5_pc", instr_pc, 64'h0);

        // Memory never answers.
        do_reset();
        mute = 1;
        wait_read(20);
        a0 = rd_addr;
        n0 = n_rd;
`ifdef FETCH_TIMEOUT_EN
        k = 0;
        do begin
            tick();
            k++;
        end while (!fetch_err && k < 40);
        chk("s6_err_latency", k, 16);
        out_busy = 0;
        mem_pend = 0;
        wait_read(10);
        chk("s6_retry_addr", rd_addr, a0);
        chk("s6_err_sticky", fetch_err, 1);
`else
        repeat (40) tick();
        chk("s6_no_retry", n_rd, n0);
        chk("s6_err", fetch_err, 0);
        chk("s6_addr_held", imem_addr, a0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
